ysyx_23060062_ifu_prefetch: RTL and testbench

- Parametrised instruction fetch unit for the ysyx_23060062 core. It replaces the single-register fetch with a credit-controlled prefetch queue.
- It issues pipelined word reads to instruction memory over a req/gnt/rvalid handshake, and buffers responses with their PCs in a DEPTH-entry FIFO.
- It hands instructions to decode over a valid/ready handshake. A redirect from branch/jump writeback flushes the queue and restarts fetch.

---
 rtl/ysyx_23060062_ifu_prefetch.sv | 102 ++++++++++
 tb/tb_ysyx_23060062_ifu_prefetch.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060062_ifu_prefetch.sv
// ysyx_23060062_ifu_prefetch: credit-controlled prefetching instruction fetch unit.
// Issues pipelined word reads and queues in-order responses with their PCs for decode.
module ysyx_23060062_ifu_prefetch #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_err,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_err,
    output logic            busy
);
    localparam int unsigned     CW   = $clog2(DEPTH + 1);
    localparam int unsigned     PW   = $clog2(DEPTH);
    localparam logic [CW:0]     CAP  = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] STEP = XLEN'(4);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, hold_addr_q, target;
    logic            hold_q, hold_d;
    logic [CW-1:0]   outs_q, outs_d, disc_q, disc_d, occ_q, occ_d;
    logic [PW-1:0]   rd_q, wr_q;
    logic [XLEN-1:0] data_q [DEPTH];
    logic [XLEN-1:0] pcs_q [DEPTH];
    logic [DEPTH-1:0] err_q;
    logic            issue, grant, resp, redir, push, pop;

    // A raised request is held (address included) until granted, whatever else happens.
    always_comb begin
        issue      = state_q == RUN && !hold_q && ({1'b0, occ_q} + {1'b0, outs_q}) < CAP;
        mem_req    = hold_q || issue;
        mem_addr   = hold_q ? hold_addr_q : fetch_pc_q;
        grant      = mem_req && mem_gnt;
        resp       = mem_rvalid && outs_q != '0;
        redir      = redirect_valid && state_q != IDLE;
        push       = resp && !redir && disc_q == '0;
        pop        = inst_valid && inst_ready;
        target     = {redirect_pc[XLEN-1:2], 2'b00};
        hold_d     = mem_req && !mem_gnt;
        outs_d     = outs_q + CW'(grant) - CW'(resp);
        disc_d     = redir && state_q == RUN ? outs_d + CW'(hold_d) : disc_q - CW'(resp && disc_q != '0);
        fetch_pc_d = redir ? target : grant && state_q == RUN ? fetch_pc_q + STEP : fetch_pc_q;
        resp_pc_d  = redir ? target : push ? resp_pc_q + STEP : resp_pc_q;
        occ_d      = redir ? '0 : occ_q + CW'(push) - CW'(pop);
        state_d    = state_q == IDLE ? RUN :
                     (state_q == DRAIN || redir) && (disc_d != '0 || hold_d) ? DRAIN : RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            resp_pc_q   <= RESET_PC;
            hold_addr_q <= RESET_PC;
            hold_q      <= 1'b0;
            outs_q      <= '0;
            disc_q      <= '0;
            occ_q       <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            resp_pc_q   <= resp_pc_d;
            hold_addr_q <= mem_addr;
            hold_q      <= hold_d;
            outs_q      <= outs_d;
            disc_q      <= disc_d;
            occ_q       <= occ_d;
            rd_q        <= redir ? '0 : rd_q + PW'(pop);
            wr_q        <= redir ? '0 : wr_q + PW'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_q] <= mem_rdata;
            pcs_q[wr_q]  <= resp_pc_q;
            err_q[wr_q]  <= mem_err;
        end
    end

    assign inst_valid = occ_q != '0;
    assign inst       = inst_valid ? data_q[rd_q] : '0;
    assign inst_pc    = inst_valid ? pcs_q[rd_q] : '0;
    assign inst_err   = inst_valid && err_q[rd_q];
    assign busy       = outs_q != '0 || state_q == DRAIN;
endmodule

// File: tb/tb_ysyx_23060062_ifu_prefetch.sv
// tb_ysyx_23060062_ifu_prefetch: randomized memory/decoder environment with an in-order PC-stream reference.
module tb_ysyx_23060062_ifu_prefetch;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, mem_req, mem_gnt, mem_rvalid, mem_err, redirect_valid;
    logic        inst_valid, inst_ready, inst_err, busy;
    logic [31:0] mem_addr, mem_rdata, redirect_pc, inst, inst_pc;

    always #5 clk = ~clk;

    ysyx_23060062_ifu_prefetch #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err), .busy(busy)
    );

    int          n_vec = 0, n_bad = 0, cyc = 0, since_rst = 0, grants = 0, accepted = 0, saw_err = 0;
    int          gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1, redir_pct = 0, late_n = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic [31:0] exp_pc = RESET_PC, err_pc = 32'h8000_0010, prev_addr = '0;
    logic [31:0] first_gnt = '0, last_gnt = '0, first_acc = '0;
    logic        prev_hold = 1'b0, expect_empty = 1'b0, late_rv = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // One clock: drive inputs at the falling edge, then observe and advance the reference.
    task automatic tick(input bit do_redir = 1'b0, input logic [31:0] rpc = '0);
        @(negedge clk);
        cyc++;
        mem_gnt    = $urandom_range(99) < gnt_pct;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        mem_err    = 1'b0;
        late_rv    = 1'b0;
        if (late_n > 0) begin
            mem_rvalid = 1'b1;
            late_rv    = 1'b1;
            mem_rdata  = 32'hBAD0_0000 | late_n;
            late_n--;
        end else if (q_addr.size() != 0 && q_due[0] <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(q_addr[0]);
            mem_err    = q_addr[0] == err_pc;
        end
        inst_ready     = $urandom_range(99) < rdy_pct;
        redirect_valid = do_redir;
        redirect_pc    = rpc;
        if (!do_redir && since_rst >= 2 && $urandom_range(999) < redir_pct) begin
            redirect_valid = 1'b1;
            redirect_pc    = $urandom;
        end
        #1;
        if (!rst) begin
            if (q_addr.size() != 0) check("busy_outstanding", 32'(busy), 1);
            if (expect_empty) check("flush_empty", 32'(inst_valid), 0);
            expect_empty = 1'b0;
            if (prev_hold) begin
                check("req_held", 32'(mem_req), 1);
                check("addr_held", mem_addr, prev_addr);
            end
            if (mem_req) check("addr_align", 32'(mem_addr[1:0]), 0);
            if (inst_valid && inst_ready) begin
                if (accepted == 0) first_acc = inst_pc;
                check("inst_pc", inst_pc, exp_pc);
                check("inst", inst, mem_word(exp_pc));
                check("inst_err", 32'(inst_err), 32'(exp_pc == err_pc));
                if (exp_pc == err_pc) saw_err++;
                exp_pc += 4;
                accepted++;
            end
            if (redirect_valid) begin
                exp_pc       = {redirect_pc[31:2], 2'b00};
                expect_empty = 1'b1;
            end
            if (mem_rvalid && !late_rv) begin
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            if (mem_req && mem_gnt) begin
                if (grants == 0) first_gnt = mem_addr;
                grants++;
                last_gnt = mem_addr;
                q_addr.push_back(mem_addr);
                q_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
            end
            check("credit_limit", 32'(q_addr.size() <= DEPTH), 1);
            prev_hold = mem_req && !mem_gnt;
            prev_addr = mem_addr;
        end
        since_rst++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q_addr.delete();
        q_due.delete();
        prev_hold    = 1'b0;
        expect_empty = 1'b0;
        tick();
        tick();
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_addr", mem_addr, RESET_PC);
        check("rst_inst_valid", 32'(inst_valid), 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_inst_err", 32'(inst_err), 0);
        check("rst_busy", 32'(busy), 0);
        rst       = 1'b0;
        since_rst = 0;
        exp_pc    = RESET_PC;
        grants    = 0;
        accepted  = 0;
    endtask

    initial begin
        rst = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        // Reset release, full-rate memory: first instruction three cycles after rst falls.
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        tick();
        check("t1_req", 32'(mem_req), 1);
        check("t1_addr0", mem_addr, RESET_PC);
        check("t1_valid_c1", 32'(inst_valid), 0);
        tick();
        check("t1_addr1", mem_addr, RESET_PC + 4);
        check("t1_valid_c2", 32'(inst_valid), 0);
        tick();
        check("t1_valid_c3", 32'(inst_valid), 1);
        check("t1_first_pc", inst_pc, RESET_PC);
        check("t1_addr2", mem_addr, RESET_PC + 8);
        repeat (10) tick();
        // Credit limit with a stalled decoder, then one pop frees exactly one request.
        rdy_pct = 0;
        do_reset();
        repeat (12) tick();
        check("t2_grants", grants, 4);
        check("t2_req_off", 32'(mem_req), 0);
        check("t2_head_pc", inst_pc, RESET_PC);
        rdy_pct = 100;
        tick();
        rdy_pct = 0;
        repeat (6) tick();
        check("t2_grants_after_pop", grants, 5);
        check("t2_next_addr", last_gnt, RESET_PC + 16);
        check("t2_req_off2", 32'(mem_req), 0);
        // Grant withheld: request and address hold until gnt rises.
        gnt_pct = 0; rdy_pct = 100;
        do_reset();
        repeat (5) begin
            tick();
            check("t3_req", 32'(mem_req), 1);
            check("t3_addr", mem_addr, RESET_PC);
        end
        gnt_pct = 100;
        tick();
        check("t3_grant", grants, 1);
        check("t3_grant_addr", last_gnt, RESET_PC);
        // Redirect with two fetches in flight and one request pending.
        lat_min = 3; lat_max = 3;
        do_reset();
        for (int i = 0; i < 20 && grants < 4; i++) tick();
        gnt_pct = 0;
        for (int i = 0; i < 20 && q_addr.size() != 2; i++) tick();
        check("t4_inflight_n", q_addr.size(), 2);
        check("t4_inflight0", q_addr[0], RESET_PC + 8);
        check("t4_inflight1", q_addr[1], RESET_PC + 12);
        tick(1'b1, 32'h8000_0102);
        gnt_pct = 100; lat_min = 1; lat_max = 3; accepted = 0;
        repeat (30) tick();
        check("t4_progress", 32'(accepted > 0), 1);
        check("t4_first_pc", first_acc, 32'h8000_0100);
        // Fault flag on exactly one entry, then an address wrap.
        lat_min = 1; lat_max = 2; saw_err = 0;
        do_reset();
        repeat (25) tick();
        check("t5_err_seen", saw_err, 1);
        tick(1'b1, 32'hFFFF_FFFA);
        accepted = 0;
        repeat (25) tick();
        check("t6_wrap_progress", 32'(accepted >= 5), 1);
        // Reset mid-transaction, then late responses must be ignored.
        rdy_pct = 0; gnt_pct = 100; lat_min = 4; lat_max = 4;
        repeat (6) tick();
        do_reset();
        gnt_pct = 0; late_n = 3;
        repeat (3) begin
            tick();
            check("t7_no_inst", 32'(inst_valid), 0);
            check("t7_not_busy", 32'(busy), 0);
        end
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 2;
        repeat (15) tick();
        check("t7_restart_addr", first_gnt, RESET_PC);
        check("t7_first_pc", first_acc, RESET_PC);
        // Randomized traffic with occasional redirects.
        gnt_pct = 70; rdy_pct = 60; lat_min = 1; lat_max = 4; redir_pct = 20;
        repeat (2000) tick();
        redir_pct = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
